// File: rtl/shiftreg_stream_checker.sv
// Receive-side scoreboard for the shift-register datapath.
// Expected words are queued in an in-order FIFO (Depth+1 entries).
// Each observed beat is compared against the FIFO head, or against the same-cycle
// expected word when the FIFO is empty. The result counters and flags are registered.
module shiftreg_stream_checker #(
  parameter int Depth         = 4,
  parameter int DataWidth     = 32,
  parameter int CountWidth    = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CountWidth-1:0] expected_num_i,
  input  logic                  exp_valid_i,
  input  logic [DataWidth-1:0]  exp_data_i,
  input  logic                  obs_valid_i,
  input  logic [DataWidth-1:0]  obs_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CountWidth-1:0] match_count_o,
  output logic [CountWidth-1:0] err_count_o,
  output logic [CountWidth-1:0] first_err_idx_o,
  output logic [DataWidth-1:0]  first_err_exp_o,
  output logic [DataWidth-1:0]  first_err_obs_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  timeout_o
);

  localparam int FifoDepth = Depth + 1;
  localparam int PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int OccW      = $clog2(FifoDepth + 1);
  localparam int IdleW     = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [PtrW-1:0]       PtrLast   = PtrW'(FifoDepth - 1);
  localparam logic [OccW-1:0]       OccFull   = OccW'(FifoDepth);
  localparam logic [IdleW-1:0]      IdleLimit = IdleW'(TimeoutCycles);
  localparam logic [CountWidth-1:0] CntMax    = '1;

  logic [1:0]            state_q, state_d;
  logic [CountWidth-1:0] n_q, n_d;
  logic [CountWidth-1:0] beat_q, beat_d;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic [DataWidth-1:0]  mem_q [FifoDepth];
  logic [DataWidth-1:0]  mem_d [FifoDepth];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [CountWidth-1:0] match_q, match_d, err_q, err_d, fidx_q, fidx_d;
  logic [DataWidth-1:0]  fexp_q, fexp_d, fobs_q, fobs_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, to_q, to_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic                  fifo_pop_s, bypass_s, under_s, push_s, write_s;
  logic [DataWidth-1:0]  cmp_exp_s;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] c);
    return (c == CntMax) ? c : c + CountWidth'(1);
  endfunction

  // Next-state: FSM, FIFO bookkeeping, compare and result registers
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    beat_d   = beat_q;
    idle_d   = idle_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    match_d  = match_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fexp_d   = fexp_q;
    fobs_d   = fobs_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    to_d     = to_q;
    fifo_pop_s = 1'b0;
    bypass_s   = 1'b0;
    under_s    = 1'b0;
    push_s     = 1'b0;
    write_s    = 1'b0;
    cmp_exp_s  = mem_q[rd_ptr_q];

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d  = StRun;
          n_d      = expected_num_i;
          beat_d   = '0;
          idle_d   = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          occ_d    = '0;
          match_d  = '0;
          err_d    = '0;
          fidx_d   = '0;
          fexp_d   = '0;
          fobs_d   = '0;
          ovf_d    = 1'b0;
          udf_d    = 1'b0;
          to_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      StRun: begin
        if (n_q == '0) begin
          // Zero-length run completes immediately with nothing to compare.
          state_d = StDone;
        end else begin
          fifo_pop_s = obs_valid_i && (occ_q != '0);
          bypass_s   = obs_valid_i && (occ_q == '0) && exp_valid_i;
          under_s    = obs_valid_i && (occ_q == '0) && !exp_valid_i;
          cmp_exp_s  = fifo_pop_s ? mem_q[rd_ptr_q] : exp_data_i;

          if (obs_valid_i) begin
            beat_d = sat_inc(beat_q);
            idle_d = '0;
            if (!under_s && (obs_data_i == cmp_exp_s)) begin
              match_d = sat_inc(match_q);
            end else begin
              err_d = sat_inc(err_q);
              if (err_q == '0) begin
                fidx_d = beat_q;
                fexp_d = under_s ? '0 : cmp_exp_s;
                fobs_d = obs_data_i;
              end else begin
                fidx_d = fidx_q;
              end
            end
            if (under_s) begin
              udf_d = 1'b1;
            end else begin
              udf_d = udf_q;
            end
            // Widened so a saturated beat counter cannot wrap into a false match.
            if (({1'b0, beat_q} + {{CountWidth{1'b0}}, 1'b1}) == {1'b0, n_q}) begin
              state_d = StDone;
            end else begin
              state_d = StRun;
            end
          end else begin
            idle_d = idle_q + IdleW'(1);
            if ((idle_q + IdleW'(1)) == IdleLimit) begin
              state_d = StDone;
              to_d    = 1'b1;
            end else begin
              state_d = StRun;
            end
          end

          // A bypassed word was consumed directly and never enters the FIFO.
          push_s  = exp_valid_i && !bypass_s;
          write_s = push_s && (fifo_pop_s || (occ_q != OccFull));
          if (push_s && !write_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (write_s) begin
            mem_d[wr_ptr_q] = exp_data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
          if (fifo_pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
          case ({write_s, fifo_pop_s})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
          endcase
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0) && !ovf_d && !udf_d && !to_d;
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      n_q      <= '0;
      beat_q   <= '0;
      idle_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      match_q  <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fexp_q   <= '0;
      fobs_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      beat_q   <= beat_d;
      idle_q   <= idle_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      match_q  <= match_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fexp_q   <= fexp_d;
      fobs_q   <= fobs_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mem_q    <= mem_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign match_count_o   = match_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = fidx_q;
  assign first_err_exp_o = fexp_q;
  assign first_err_obs_o = fobs_q;
  assign overflow_o      = ovf_q;
  assign underflow_o     = udf_q;
  assign timeout_o       = to_q;

endmodule
